signed_digit_recompose: RTL and testbench
=========================================

SIGNED_DIGIT_RECOMPOSE -- requirements
Module: signed_digit_recompose

Interface
REQ-001 Parameter: DATA_W, 32, width of digit and coefficient words.
REQ-002 Parameter: Q, 12289, ring modulus; Q < 2^(DATA_W-1) SHALL hold.
REQ-003 Parameter: LOG_B, 4, base-2 log of gadget base B.
REQ-004 Parameter: DIGITS, 4, signed digits per coefficient; B^DIGITS > Q SHALL hold.
REQ-005 Port: clk  input  1  single clock; all state on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-low reset.
REQ-007 Port: in_valid  input  1  in_digit valid.
REQ-008 Port: in_ready  output  1  block accepts a digit this cycle.
REQ-009 Port: in_digit  input  DATA_W  signed digit in mod-Q form (d < Q/2 is +d, else d-Q), MSD first.
REQ-010 Port: out_valid  output  1  out_data holds a recomposed coefficient.
REQ-011 Port: out_ready  input  1  downstream accepts out_data.
REQ-012 Port: out_data  output  DATA_W  recomposed coefficient, range [0,Q).
REQ-013 Port: busy  output  1  a coefficient is partially recomposed or awaiting output.
REQ-014 Port: err  output  1  sticky digit range error.

Function
REQ-015 The block SHALL compute out_data = sum(d_i * B^i) mod Q by Horner: acc <- (acc*B + d) mod Q per digit, MSD first, acc starting at 0.
REQ-016 FSM states SHALL be ACC, DBL, OUT; reset state ACC.
REQ-017 ACC: in_ready=1; on in_valid&in_ready, acc <- acc+d, minus Q if sum >= Q (DATA_W+1-bit intermediate); digit counter increments.
REQ-018 ACC transition: after the DIGITS-th accepted digit go to OUT, otherwise go to DBL with shift counter 0; no handshake means stay in ACC.
REQ-019 DBL: in_ready=0; each cycle acc <- 2*acc, minus Q if result >= Q; after exactly LOG_B cycles go to ACC.
REQ-020 OUT: out_valid=1, out_data=acc held stable, in_ready=0; on out_ready go to ACC with acc=0 and digit counter=0.
REQ-021 out_data SHALL read 0 whenever out_valid=0.
REQ-022 With in_valid held high and out_ready high, latency from first digit handshake to out_valid SHALL be DIGITS+(DIGITS-1)*LOG_B cycles (16 with defaults); throughput 1 coefficient per 17 cycles.
REQ-023 Gaps in in_valid SHALL stall in ACC without altering acc or counters.
REQ-024 out_ready low SHALL stall indefinitely in OUT; input is not accepted (no overlap).
REQ-025 busy SHALL be 1 when state!=ACC or digit counter!=0.

Reset
REQ-026 Reset assertion at any time, including mid-coefficient, SHALL asynchronously force state ACC, acc=0, counters=0, out_valid=0, out_data=0, err=0, busy=0, in_ready=1; partial results are discarded.
REQ-027 err SHALL clear only by reset.

Configuration
REQ-028 Macro RECOMPOSE_RANGE_CHECK_EN defined: an accepted digit with in_digit >= Q SHALL set err and be added as 0.
REQ-029 Macro undefined: no range check, err tied 0, digits used raw (result for in_digit >= Q is unspecified but SHALL NOT hang the FSM).

Verification (Q=12289, LOG_B=4, DIGITS=4)
REQ-030 Digits 1,4,12282,12281 back-to-back, out_ready=1 -> out_valid at cycle 16 after first handshake, out_data=5000, busy low next cycle.
REQ-031 Digits 0,0,0,12288 -> out_data=12288 (value -1); digits 7,7,7,7 -> out_data=6005 (wrap reduction).
REQ-032 Coefficient complete, out_ready low 5 cycles -> out_valid=1 and out_data stable for 5 cycles, in_ready=0, then 1 cycle after out_ready rises.
REQ-033 in_valid toggled every other cycle for digits 1,4,12282,12281 -> out_data=5000, acc unaffected by gaps.
REQ-034 Reset pulsed after 2 digits -> all outputs 0, in_ready=1; next full sequence 0,0,0,5 -> out_data=5.
REQ-035 With RECOMPOSE_RANGE_CHECK_EN: digits 12289,0,0,5 -> out_data=5, err=1 sticky until reset; without the macro, err stays 0.

Source files
------------

// File: rtl/signed_digit_recompose.sv
// signed_digit_recompose
//   Recomposes a coefficient from DIGITS signed gadget digits (base B = 2^LOG_B),
//   most significant digit first, using Horner's rule modulo Q:
//     acc <- (acc * B + d) mod Q
//   The multiply by B is done as LOG_B modular doublings. Each doubling takes
//   one cycle. Each digit is added in the ACC state. The finished coefficient
//   is then presented in the OUT state and held there until it is taken.
//
//   Digits arrive in mod-Q form. A value d >= Q/2 stands for d - Q. Because
//   d and d - Q are congruent mod Q, a plain modular add handles both cases.
//
//   Optional feature (compile-time macro RECOMPOSE_RANGE_CHECK_EN):
//     defined   - an accepted digit with in_digit >= Q sets the sticky err flag
//                 and is added as 0.
//     undefined - digits are used raw and err is tied to 0.
//
//   reset is asynchronous and active-low.
module signed_digit_recompose #(
  parameter int DATA_W = 32,
  parameter int Q      = 12289,
  parameter int LOG_B  = 4,
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_digit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err
);

  localparam int DCNT_W = $clog2(DIGITS + 1);
  localparam int SCNT_W = $clog2(LOG_B + 1);

  // Q widened by one bit, so that the sum of two values below Q never overflows.
  localparam logic [DATA_W:0]   Q_EXT      = (DATA_W + 1)'(Q);
  localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(DIGITS - 1);
  localparam logic [SCNT_W-1:0] LAST_SHIFT = SCNT_W'(LOG_B - 1);

  typedef enum logic [1:0] {
    ACC = 2'd0,
    DBL = 2'd1,
    OUT = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [DCNT_W-1:0]   dig_cnt;
  logic [SCNT_W-1:0]   sh_cnt;

  logic [DATA_W-1:0]   digit_eff;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     dbl_sum;
  logic [DATA_W-1:0]   add_red;
  logic [DATA_W-1:0]   dbl_red;

`ifdef RECOMPOSE_RANGE_CHECK_EN
  logic digit_bad;

  // An out-of-range digit is replaced by 0, so the coefficient stays in [0,Q).
  assign digit_bad = (in_digit >= Q_EXT[DATA_W-1:0]);
  assign digit_eff = digit_bad ? '0 : in_digit;

  // Sticky error flag. Only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (state == ACC && in_valid && digit_bad) begin
      err <= 1'b1;
    end
  end
`else
  assign digit_eff = in_digit;
  assign err       = 1'b0;
`endif

  // Modular add of the digit and modular doubling of acc, each with one
  // conditional subtract of Q.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here up
    // front), otherwise synthesis infers a latch.
    add_sum = {1'b0, acc} + {1'b0, digit_eff};
    dbl_sum = {acc, 1'b0};
    add_red = (add_sum >= Q_EXT) ? DATA_W'(add_sum - Q_EXT) : DATA_W'(add_sum);
    dbl_red = (dbl_sum >= Q_EXT) ? DATA_W'(dbl_sum - Q_EXT) : DATA_W'(dbl_sum);
  end

  // Handshake and status flags come straight from registered state.
  assign in_ready = (state == ACC);
  assign busy     = (state != ACC) || (dig_cnt != '0);

  // Recomposition FSM with registered coefficient output.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // in this block samples values from before the clock edge.
    if (!reset) begin
      state     <= ACC;
      acc       <= '0;
      dig_cnt   <= '0;
      sh_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        ACC: begin
          if (in_valid) begin
            acc     <= add_red;
            dig_cnt <= dig_cnt + 1'b1;
            if (dig_cnt == LAST_DIGIT) begin
              state     <= OUT;
              out_valid <= 1'b1;
              out_data  <= add_red;
            end else begin
              state  <= DBL;
              sh_cnt <= '0;
            end
          end
        end

        DBL: begin
          acc    <= dbl_red;
          sh_cnt <= sh_cnt + 1'b1;
          if (sh_cnt == LAST_SHIFT) begin
            state <= ACC;
          end
        end

        OUT: begin
          if (out_ready) begin
            state     <= ACC;
            acc       <= '0;
            dig_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
          end
        end

        default: begin
          state <= ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_digit_recompose.sv
// Directed testbench for signed_digit_recompose (Q=12289, LOG_B=4, DIGITS=4).
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
// Compile with RECOMPOSE_RANGE_CHECK_EN to exercise the range-check build.
module tb_signed_digit_recompose;

  localparam int DATA_W = 32;
  localparam int Q      = 12289;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_digit;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  signed_digit_recompose #(
    .DATA_W(DATA_W),
    .Q     (Q),
    .LOG_B (4),
    .DIGITS(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_digit (in_digit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .err      (err)
  );

  // Stimulus driver. It must be called at a falling edge, and it returns at a
  // falling edge. It feeds four digits, MSD first. When gaps is set, in_valid
  // toggles every cycle. The task reports two values. lat is the number of
  // cycles from the first handshake to the return point. first_cyc is the
  // number of cycles that passed before the first handshake.
  task automatic drive_coef(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                            input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3,
                            input bit gaps, output int lat, output int first_cyc);
    logic [DATA_W-1:0] d [4];
    int idx;
    int cyc;
    bit hs;
    bit tog;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    idx = 0; cyc = 0; tog = 1'b1; lat = -1; first_cyc = -1;
    while (idx < 4 && cyc < 300) begin
      in_valid = gaps ? tog : 1'b1;
      in_digit = d[idx];
      tog      = ~tog;
      hs       = in_valid && in_ready;
      if (hs && idx == 0) first_cyc = cyc;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    in_digit = '0;
    n_cmp++;
    if (idx != 4) begin
      n_bad++;
      $display("FAIL drive_timeout: accepted %0d digits, required 4", idx);
    end else begin
      lat = cyc - first_cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_digit = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, busy, err, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b data=%0d busy=%b err=%b ready=%b, want 0 0 0 0 1",
               out_valid, out_data, busy, err, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, fc;
    drive_coef(32'd1, 32'd4, 32'd12282, 32'd12281, 1'b0, lat, fc);
    n_cmp++;
    if (lat !== 16) begin n_bad++; $display("FAIL basic_latency: got %0d, want 16", lat); end
    n_cmp++;
    if ({out_valid, busy, in_ready} !== 3'b110) begin
      n_bad++; $display("FAIL basic_flags: got valid/busy/ready=%b%b%b, want 110", out_valid, busy, in_ready);
    end
    n_cmp++;
    if (out_data !== 32'd5000) begin n_bad++; $display("FAIL basic_data: got %0d, want 5000", out_data); end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, in_ready, out_data} !== {1'b0, 1'b0, 1'b1, 32'd0}) begin
      n_bad++; $display("FAIL basic_release: got valid=%b busy=%b ready=%b data=%0d, want 0 0 1 0",
                        out_valid, busy, in_ready, out_data);
    end
  endtask

  task automatic test_negative();
    int lat, fc;
    drive_coef(32'd0, 32'd0, 32'd0, 32'd12288, 1'b0, lat, fc);
    n_cmp++;
    if (!out_valid || out_data !== 32'd12288) begin
      n_bad++; $display("FAIL neg_one: got valid=%b data=%0d, want 1 12288", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int lat, fc;
    drive_coef(32'd7, 32'd7, 32'd7, 32'd7, 1'b0, lat, fc);
    n_cmp++;
    if (!out_valid || out_data !== 32'd6005) begin
      n_bad++; $display("FAIL wrap_7777: got valid=%b data=%0d, want 1 6005", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_out_stall();
    int lat, fc;
    out_ready = 1'b0;
    drive_coef(32'd7, 32'd7, 32'd7, 32'd7, 1'b0, lat, fc);
    // An offered digit must not be taken while the result is pending.
    in_valid = 1'b1; in_digit = 32'd3;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 32'd6005}) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got valid=%b ready=%b data=%0d, want 1 0 6005",
                          i, out_valid, in_ready, out_data);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_digit = '0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++; $display("FAIL stall_release: got valid/ready/busy=%b%b%b, want 010", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_gaps();
    int lat, fc;
    drive_coef(32'd1, 32'd4, 32'd12282, 32'd12281, 1'b1, lat, fc);
    n_cmp++;
    if (!out_valid || out_data !== 32'd5000) begin
      n_bad++; $display("FAIL gaps_data: got valid=%b data=%0d, want 1 5000", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, fc;
    in_valid = 1'b1; in_digit = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b1; in_digit = 32'd2;
    @(negedge clk);
    in_valid = 1'b0; in_digit = '0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b, want 1", busy); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, busy, err, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL mid_reset: got valid=%b data=%0d busy=%b err=%b ready=%b, want 0 0 0 0 1",
                        out_valid, out_data, busy, err, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive_coef(32'd0, 32'd0, 32'd0, 32'd5, 1'b0, lat, fc);
    n_cmp++;
    if (lat !== 16 || !out_valid || out_data !== 32'd5) begin
      n_bad++; $display("FAIL mid_after: got lat=%0d valid=%b data=%0d, want 16 1 5", lat, out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, fc;
    drive_coef(32'd1, 32'd0, 32'd0, 32'd0, 1'b0, lat, fc);
    n_cmp++;
    if (!out_valid || out_data !== 32'd4096) begin
      n_bad++; $display("FAIL b2b_first: got valid=%b data=%0d, want 1 4096", out_valid, out_data);
    end
    // The next call begins in the OUT cycle, so one idle cycle is expected
    // before the first handshake. That gives one coefficient per 17 cycles.
    drive_coef(32'd0, 32'd1, 32'd0, 32'd0, 1'b0, lat, fc);
    n_cmp++;
    if (fc !== 1) begin n_bad++; $display("FAIL b2b_throughput: got first handshake at %0d, want 1", fc); end
    n_cmp++;
    if (!out_valid || out_data !== 32'd256) begin
      n_bad++; $display("FAIL b2b_second: got valid=%b data=%0d, want 1 256", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_range();
    int lat, fc;
    drive_coef(32'd12289, 32'd0, 32'd0, 32'd5, 1'b0, lat, fc);
`ifdef RECOMPOSE_RANGE_CHECK_EN
    n_cmp++;
    if (!out_valid || out_data !== 32'd5 || err !== 1'b1) begin
      n_bad++; $display("FAIL range_flag: got valid=%b data=%0d err=%b, want 1 5 1", out_valid, out_data, err);
    end
    @(negedge clk);
    drive_coef(32'd0, 32'd0, 32'd0, 32'd1, 1'b0, lat, fc);
    n_cmp++;
    if (err !== 1'b1 || out_data !== 32'd1) begin
      n_bad++; $display("FAIL range_sticky: got err=%b data=%0d, want 1 1", err, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL range_clear: got err=%b, want 0", err); end
`else
    n_cmp++;
    if (!out_valid || err !== 1'b0) begin
      n_bad++; $display("FAIL range_off: got valid=%b err=%b, want 1 0", out_valid, err);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_wrap();
    test_out_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
